// File: rtl/axil_upi_pkg.sv
// ---------------------------------------------------------------------------
// axil_upi_pkg : shared response codes, FSM encodings and defaults. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package axil_upi_pkg;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_WR_ACC  = 3'd1;
  localparam logic [2:0] ST_RD_ACC  = 3'd2;
  localparam logic [2:0] ST_WR_RESP = 3'd3;
  localparam logic [2:0] ST_RD_RESP = 3'd4;

  localparam logic [31:0] TIMEOUT_D_DEF = 32'hCAFE_CAFE;
endpackage

`default_nettype wire

// File: rtl/axil_upi_tmo.sv
// ---------------------------------------------------------------------------
// axil_upi_tmo : access timeout counter, fires after 2**TIMEOUT_W-1 cycles. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module axil_upi_tmo #(
  parameter int TIMEOUT_W = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic run,
  output logic expire,
  output logic tmo_evt
);
  localparam logic [TIMEOUT_W-1:0] CNT_ONE = TIMEOUT_W'(1);
  localparam logic [TIMEOUT_W-1:0] CNT_MAX = {TIMEOUT_W{1'b1}};
  localparam logic [TIMEOUT_W-1:0] CNT_PRE = CNT_MAX - CNT_ONE;

  logic [TIMEOUT_W-1:0] r_cnt;

  // The counter lands on all-ones at the very edge that ends the access.
  assign expire = run && (r_cnt == CNT_PRE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      tmo_evt <= 1'b0;
    end else begin
      tmo_evt <= expire;
      if (clr) begin
        r_cnt <= '0;
      end else if (run && (r_cnt != CNT_MAX)) begin
        r_cnt <= r_cnt + CNT_ONE;
      end
    end
  end
endmodule

`default_nettype wire

// File: rtl/axil_upi_bridge.sv
// ---------------------------------------------------------------------------
// axil_upi_bridge : AXI4-Lite slave to UPI bridge; option AXIL_UPI_RANGE_CHK_EN. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module axil_upi_bridge
  import axil_upi_pkg::*;
#(
  parameter int                  AXI_ADDR  = 32,
  parameter int                  AXI_DATW  = 32,
  parameter int                  G_CPUA    = AXI_ADDR - $clog2(AXI_DATW / 8),
  parameter int                  TIMEOUT_W = 8,
  parameter logic [31:0]         TIMEOUT_D = TIMEOUT_D_DEF,
  parameter logic [G_CPUA-1:0]   UPA_MAX   = {G_CPUA{1'b1}}
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [AXI_ADDR-1:0]   s_axi_awaddr,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,
  input  logic [AXI_DATW-1:0]   s_axi_wdata,
  input  logic [AXI_DATW/8-1:0] s_axi_wstrb,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  output logic [1:0]            s_axi_bresp,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready,
  input  logic [AXI_ADDR-1:0]   s_axi_araddr,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  output logic [AXI_DATW-1:0]   s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready,
  output logic [G_CPUA-1:0]     upa,
  output logic                  upen,
  output logic                  upws,
  output logic                  uprs,
  output logic [AXI_DATW/8-1:0] upbe,
  output logic [AXI_DATW-1:0]   updi,
  input  logic [AXI_DATW-1:0]   updo,
  input  logic                  uprdy,
  output logic                  tmo_evt
);
  localparam int                ADDR_LSB = $clog2(AXI_DATW / 8);
  localparam logic [AXI_DATW-1:0] TMO_FILL = {(AXI_DATW / 32){TIMEOUT_D}};

  logic [2:0]        r_state;
  logic              r_last_wr;
  logic              w_idle;
  logic              w_wr_cand;
  logic              w_rd_cand;
  logic              w_grant_wr;
  logic              w_grant_rd;
  logic              w_in_acc;
  logic              w_expire;
  logic              w_done;
  logic              w_range_err;
  logic [G_CPUA-1:0] w_grant_word;
  logic [1:0]        w_done_resp;
  logic              unused_addr_lsbs;

  assign unused_addr_lsbs = ^{s_axi_awaddr[ADDR_LSB-1:0], s_axi_araddr[ADDR_LSB-1:0]};

  assign w_idle     = (r_state == ST_IDLE);
  assign w_wr_cand  = s_axi_awvalid & s_axi_wvalid;
  assign w_rd_cand  = s_axi_arvalid;
  // On a collision the type not served last wins; reset leaves "write" as last.
  assign w_grant_rd = w_idle & w_rd_cand & (~w_wr_cand | r_last_wr);
  assign w_grant_wr = w_idle & w_wr_cand & ~w_grant_rd;

  assign w_grant_word = w_grant_rd ? s_axi_araddr[AXI_ADDR-1:ADDR_LSB]
                                   : s_axi_awaddr[AXI_ADDR-1:ADDR_LSB];

`ifdef AXIL_UPI_RANGE_CHK_EN
  assign w_range_err = (w_grant_word > UPA_MAX);
`else
  assign w_range_err = 1'b0;
`endif

  assign w_in_acc    = (r_state == ST_WR_ACC) || (r_state == ST_RD_ACC);
  assign w_done      = w_in_acc & (uprdy | w_expire);
  assign w_done_resp = uprdy ? RESP_OKAY : RESP_SLVERR;

  assign s_axi_awready = w_grant_wr;
  assign s_axi_wready  = w_grant_wr;
  assign s_axi_arready = w_grant_rd;
  assign s_axi_bvalid  = (r_state == ST_WR_RESP);
  assign s_axi_rvalid  = (r_state == ST_RD_RESP);
  assign upen          = w_in_acc;
  assign upws          = (r_state == ST_WR_ACC);
  assign uprs          = (r_state == ST_RD_ACC);

  // uprdy wins over a same-cycle timeout, so it also stops the counter.
  axil_upi_tmo #(
    .TIMEOUT_W (TIMEOUT_W)
  ) u_tmo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (w_grant_wr | w_grant_rd),
    .run     (w_in_acc & ~uprdy),
    .expire  (w_expire),
    .tmo_evt (tmo_evt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_last_wr   <= 1'b1;
      upa         <= '0;
      upbe        <= '0;
      updi        <= '0;
      s_axi_bresp <= RESP_OKAY;
      s_axi_rresp <= RESP_OKAY;
      s_axi_rdata <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_grant_wr) begin
            upa       <= w_grant_word;
            updi      <= s_axi_wdata;
            upbe      <= s_axi_wstrb;
            r_last_wr <= 1'b1;
            if (w_range_err) begin
              s_axi_bresp <= RESP_DECERR;
              r_state     <= ST_WR_RESP;
            end else begin
              r_state <= ST_WR_ACC;
            end
          end else if (w_grant_rd) begin
            upa       <= w_grant_word;
            r_last_wr <= 1'b0;
            if (w_range_err) begin
              s_axi_rresp <= RESP_DECERR;
              s_axi_rdata <= '0;
              r_state     <= ST_RD_RESP;
            end else begin
              r_state <= ST_RD_ACC;
            end
          end
        end
        ST_WR_ACC: begin
          if (w_done) begin
            s_axi_bresp <= w_done_resp;
            r_state     <= ST_WR_RESP;
          end
        end
        ST_RD_ACC: begin
          if (w_done) begin
            s_axi_rresp <= w_done_resp;
            s_axi_rdata <= uprdy ? updo : TMO_FILL;
            r_state     <= ST_RD_RESP;
          end
        end
        ST_WR_RESP: begin
          if (s_axi_bready) r_state <= ST_IDLE;
        end
        ST_RD_RESP: begin
          if (s_axi_rready) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end
endmodule

`default_nettype wire
